uart_rx_frame_receiver: RTL

Serial UART receiver: the consumer of the serial line driven by the transmit FSM. It oversamples the asynchronous line, detects the start bit, reassembles a DATA_WIDTH-bit word LSB-first, and checks optional parity and the stop bit. It presents the word on a parallel bus with a one-cycle valid strobe, or flags a parity or stop error. Frame format matches the transmitter: start(0), data LSB-first, optional parity, stop(1).

---
 rtl/uart_rx_frame_receiver.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_receiver.sv
// uart_rx_frame_receiver
// Oversampling UART receiver. Synchronizes the asynchronous serial line,
// detects the falling edge of a start bit, majority-votes three centre
// samples per bit, reassembles a DATA_WIDTH-bit word LSB-first, checks an
// optional parity bit and the stop bit, and reports the result as
// one-cycle strobes.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous, active-high reset
//   RX_IN      serial line (asynchronous to CLK, idles high)
//   PAR_EN     1 = frame carries a parity bit (latched at start detection)
//   PAR_TYP    0 = even, 1 = odd parity (latched at start detection)
//   P_DATA     last correctly received word, updated only with DATA_VALID
//   DATA_VALID one-cycle strobe, P_DATA updated this cycle
//   PAR_ERR    one-cycle strobe, parity mismatch
//   STP_ERR    one-cycle strobe, stop bit sampled 0
module uart_rx_frame_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] SAMP_A    = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] SAMP_B    = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] SAMP_C    = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Two-of-three vote over the centre samples of a bit.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Expected parity bit for a word: even -> XOR of data, odd -> inverted XOR.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                state_r, state_nx;
  logic                  sync1_r, rx_s_r, rx_prev_r;
  logic [EW-1:0]         edge_cnt_r;
  logic [BW-1:0]         bit_cnt_r;
  logic [2:0]            samp_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_en_r, par_typ_r, par_mism_r;

  logic start_det_s, bit_end_s, bit_val_s;
  logic start_end_s, data_end_s, par_end_s, stop_end_s;

  // Two-flop synchronizer for RX_IN plus a one-cycle history for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_r   <= 1'b1;
      rx_s_r    <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= RX_IN;
      rx_s_r    <= sync1_r;
      rx_prev_r <= rx_s_r;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic and per-bit event decode.
  always_comb begin
    start_det_s = (~rx_s_r) & rx_prev_r;
    bit_end_s   = (edge_cnt_r == EDGE_LAST);
    bit_val_s   = majority3(samp_r);
    start_end_s = 1'b0;
    data_end_s  = 1'b0;
    par_end_s   = 1'b0;
    stop_end_s  = 1'b0;
    state_nx    = state_r;
    case (state_r)
      IDLE: begin
        if (start_det_s) state_nx = START;
        else             state_nx = IDLE;
      end
      START: begin
        start_end_s = bit_end_s;
        if (bit_end_s) begin
          // A start bit that votes high was a glitch: drop it silently.
          if (bit_val_s) state_nx = IDLE;
          else           state_nx = DATA;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        data_end_s = bit_end_s;
        if (bit_end_s && (bit_cnt_r == BIT_LAST)) begin
          if (par_en_r) state_nx = PARITY;
          else          state_nx = STOP;
        end else begin
          state_nx = DATA;
        end
      end
      PARITY: begin
        par_end_s = bit_end_s;
        if (bit_end_s) state_nx = STOP;
        else           state_nx = PARITY;
      end
      STOP: begin
        stop_end_s = bit_end_s;
        if (bit_end_s) state_nx = IDLE;
        else           state_nx = STOP;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Counters, sample capture, word assembly and registered result strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_r <= {EW{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      samp_r     <= 3'b000;
      shift_r    <= {DATA_WIDTH{1'b0}};
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      par_mism_r <= 1'b0;
      P_DATA     <= {DATA_WIDTH{1'b0}};
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;

      // Centre samples; edge_cnt stays 0 in IDLE so these never fire there.
      if (edge_cnt_r == SAMP_A) samp_r[0] <= rx_s_r;
      if (edge_cnt_r == SAMP_B) samp_r[1] <= rx_s_r;
      if (edge_cnt_r == SAMP_C) samp_r[2] <= rx_s_r;

      case (state_r)
        IDLE: begin
          if (start_det_s) begin
            // The detecting cycle is edge 0 of the start bit.
            edge_cnt_r <= EW'(1);
            par_en_r   <= PAR_EN;
            par_typ_r  <= PAR_TYP;
            par_mism_r <= 1'b0;
          end else begin
            edge_cnt_r <= {EW{1'b0}};
          end
        end
        START, DATA, PARITY, STOP: begin
          if (bit_end_s) edge_cnt_r <= {EW{1'b0}};
          else           edge_cnt_r <= edge_cnt_r + EW'(1);
        end
        default: begin
          edge_cnt_r <= {EW{1'b0}};
        end
      endcase

      if (start_end_s) bit_cnt_r <= {BW{1'b0}};

      if (data_end_s) begin
        shift_r[bit_cnt_r] <= bit_val_s;
        if (bit_cnt_r == BIT_LAST) bit_cnt_r <= {BW{1'b0}};
        else                       bit_cnt_r <= bit_cnt_r + BW'(1);
      end

      if (par_end_s) par_mism_r <= (calc_parity(shift_r, par_typ_r) != bit_val_s);

      if (stop_end_s) begin
        if (bit_val_s && !par_mism_r) begin
          P_DATA     <= shift_r;
          DATA_VALID <= 1'b1;
        end
        PAR_ERR <= par_mism_r;
        STP_ERR <= ~bit_val_s;
      end
    end
  end

endmodule
